// File: rtl/hazard_scoreboard.sv
// Register-dependency scoreboard beside the ID stage: counts in-flight writers per
// register and raises a stall on RAW (no bypass) or load-use (bypass enabled).
module hazard_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        forward_en,
  input  logic        freeze,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_two_src,
  input  logic        id_wb_en,
  input  logic [3:0]  id_dest,
  input  logic        id_mem_read,
  input  logic        wb_retire,
  input  logic [3:0]  wb_dest,
  output logic        hazard,
  output logic [15:0] pending_mask,
  output logic        err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] count     [16];
  logic [CNT_W-1:0] count_nxt [16];
  logic             exe_load_valid;
  logic [3:0]       exe_load_dest;

  logic        retire_now;
  logic        issue;
  logic        inc;
  logic        dec;
  logic        err_set;
  logic [15:0] rel_vec;
  logic [15:0] inc_hit;
  logic [15:0] dec_hit;

  function automatic logic luse(input logic [3:0] src, input logic ld_vld,
                                input logic [3:0] ld_dest);
    return (src != 4'd15) && ld_vld && (ld_dest == src);
  endfunction

  // Stall decision; a same-cycle retire satisfies the reader since the
  // register file writes on the falling edge.
  always_comb begin
    retire_now = wb_retire & ~freeze;
    for (int r = 0; r < 16; r++) begin
      rel_vec[r] = (r != 15) &&
                   (count[r] != ((retire_now && (wb_dest == 4'(r))) ? CNT_W'(1) : CNT_W'(0)));
    end
    hazard = 1'b0;
    if (rst && id_valid) begin
      if (forward_en)
        hazard = luse(id_src1, exe_load_valid, exe_load_dest) ||
                 (id_two_src && luse(id_src2, exe_load_valid, exe_load_dest));
      else
        hazard = rel_vec[id_src1] || (id_two_src && rel_vec[id_src2]);
    end
    issue   = id_valid & ~hazard & ~freeze & ~flush;
    inc     = issue & id_wb_en & (id_dest != 4'd15);
    dec     = retire_now & (wb_dest != 4'd15);
    inc_hit = inc ? (16'd1 << id_dest) : 16'd0;
    dec_hit = dec ? (16'd1 << wb_dest) : 16'd0;
  end

  // Counter next-state with saturation on overflow/underflow.
  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < 16; r++) begin
      count_nxt[r] = count[r];
      if (inc_hit[r] && !dec_hit[r]) begin
        if (count[r] == CNT_MAX) err_set = 1'b1;
        else                     count_nxt[r] = count[r] + CNT_W'(1);
      end else if (dec_hit[r] && !inc_hit[r]) begin
        if (count[r] == '0) err_set = 1'b1;
        else                count_nxt[r] = count[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < 16; r++) count[r] <= '0;
      exe_load_valid <= 1'b0;
      err            <= 1'b0;
    end else if (!freeze) begin
      for (int r = 0; r < 16; r++) count[r] <= count_nxt[r];
      exe_load_valid <= issue & id_mem_read & id_wb_en & (id_dest != 4'd15);
      err            <= err | err_set;
    end
  end

  // Destination tag is only meaningful alongside exe_load_valid.
  always_ff @(posedge clk) begin
    if (!freeze) exe_load_dest <= id_dest;
  end

  always_comb begin
    for (int r = 0; r < 16; r++) pending_mask[r] = (count[r] != '0);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from an in-bench reference model.
module tb_hazard_scoreboard;

  localparam int CNT_W   = 2;
  localparam int CNT_TOP = (1 << CNT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        forward_en, freeze, flush, id_valid, id_two_src, id_wb_en, id_mem_read, wb_retire;
  logic [3:0]  id_src1, id_src2, id_dest, wb_dest;
  logic        hazard, err;
  logic [15:0] pending_mask;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .forward_en(forward_en), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
    .id_wb_en(id_wb_en), .id_dest(id_dest), .id_mem_read(id_mem_read),
    .wb_retire(wb_retire), .wb_dest(wb_dest),
    .hazard(hazard), .pending_mask(pending_mask), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic fe, fz, fl, v, two, wbe, mr, ret;
    logic [3:0] s1, s2, d, wd;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        haz;
    logic [15:0] mask;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc_no     = 0;

  // Reference model: outstanding writers per register, youngest load in EXE.
  int m_cnt[16];
  int m_load;
  bit m_err;

  function automatic void model_reset();
    for (int r = 0; r < 16; r++) m_cnt[r] = 0;
    m_load = -1;
    m_err  = 0;
  endfunction

  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    for (int r = 0; r < 16; r++) m[r] = (m_cnt[r] != 0);
    return m;
  endfunction

  function automatic bit m_rel(int s, stim_t t);
    int adj;
    adj = (t.ret && !t.fz && (int'(t.wd) == s)) ? 1 : 0;
    return (s != 15) && ((m_cnt[s] - adj) != 0);
  endfunction

  function automatic bit m_luse(int s);
    return (s != 15) && (m_load == s);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t nop(input logic fe);
    stim_t s;
    s = '{fe: fe, fz: 0, fl: 0, v: 0, two: 0, wbe: 0, mr: 0, ret: 0,
          s1: 4'd0, s2: 4'd0, d: 4'd0, wd: 4'd0};
    return s;
  endfunction

  // Drive one cycle at the falling edge, predict, then advance the model.
  task automatic drive(input stim_t t);
    exp_t e;
    bit   haz, issue, inc, dec;
    @(negedge clk);
    rst = 1'b1;
    forward_en = t.fe; freeze = t.fz; flush = t.fl; id_valid = t.v;
    id_src1 = t.s1; id_src2 = t.s2; id_two_src = t.two; id_wb_en = t.wbe;
    id_dest = t.d; id_mem_read = t.mr; wb_retire = t.ret; wb_dest = t.wd;
    #1;
    if (t.fe) haz = t.v && (m_luse(t.s1) || (t.two && m_luse(t.s2)));
    else      haz = t.v && (m_rel(t.s1, t) || (t.two && m_rel(t.s2, t)));
    e.cyc = cyc_no; e.haz = haz; e.mask = model_mask(); e.err = m_err;
    exp_q.push_back(e);
    cyc_no++;
    issue = t.v && !haz && !t.fz && !t.fl;
    inc   = issue && t.wbe && (t.d != 4'd15);
    dec   = t.ret && !t.fz && (t.wd != 4'd15);
    if (!(inc && dec && t.d == t.wd)) begin
      if (inc) begin
        if (m_cnt[t.d] == CNT_TOP) m_err = 1; else m_cnt[t.d]++;
      end
      if (dec) begin
        if (m_cnt[t.wd] == 0) m_err = 1; else m_cnt[t.wd]--;
      end
    end
    if (!t.fz) m_load = (issue && t.mr && t.wbe && t.d != 4'd15) ? int'(t.d) : -1;
  endtask

  // Reset held across a rising edge while ID shows a valid reader of R3.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; id_valid = 1'b1; id_src1 = 4'd3; id_src2 = 4'd3; id_two_src = 1'b1;
    forward_en = 1'b0; freeze = 1'b0; flush = 1'b0; id_wb_en = 1'b1; id_dest = 4'd3;
    id_mem_read = 1'b0; wb_retire = 1'b0; wb_dest = 4'd0;
    model_reset();
    #2;
    chk("rst_hazard", {15'd0, hazard}, 16'd0);
    chk("rst_mask", pending_mask, 16'd0);
    chk("rst_err", {15'd0, err}, 16'd0);
  endtask

  // Reset asserted between clock edges must clear state immediately.
  task automatic async_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk("arst_mask", pending_mask, 16'd0);
    chk("arst_err", {15'd0, err}, 16'd0);
    chk("arst_hazard", {15'd0, hazard}, 16'd0);
  endtask

  function automatic logic [3:0] rreg();
    return ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    int    pq[$];
    s = nop($urandom_range(0, 1) == 1);
    s.fz = ($urandom_range(0, 7) == 0);
    s.fl = ($urandom_range(0, 9) == 0);
    s.v  = ($urandom_range(0, 3) != 0);
    s.s1 = rreg(); s.s2 = rreg(); s.two = $urandom_range(0, 1) == 1;
    s.wbe = ($urandom_range(0, 3) != 0); s.d = rreg(); s.mr = ($urandom_range(0, 2) == 0);
    for (int r = 0; r < 16; r++) if (m_cnt[r] > 0) pq.push_back(r);
    if (pq.size() > 0 && $urandom_range(0, 1) == 1) begin
      s.ret = 1; s.wd = 4'(pq[$urandom_range(0, pq.size() - 1)]);
    end else if ($urandom_range(0, 19) == 0) begin
      s.ret = 1; s.wd = rreg();
    end
    return s;
  endfunction

  // Monitor: compares each presented cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compared += 3;
        if (hazard !== e.haz) begin
          mismatched++;
          $display("FAIL hazard cyc=%0d got=%b expected=%b", e.cyc, hazard, e.haz);
        end
        if (pending_mask !== e.mask) begin
          mismatched++;
          $display("FAIL pending_mask cyc=%0d got=%h expected=%h", e.cyc, pending_mask, e.mask);
        end
        if (err !== e.err) begin
          mismatched++;
          $display("FAIL err cyc=%0d got=%b expected=%b", e.cyc, err, e.err);
        end
      end
    end
  end

  initial begin
    stim_t s;
    rst = 1'b0; forward_en = 0; freeze = 0; flush = 0; id_valid = 0; id_src1 = 0;
    id_src2 = 0; id_two_src = 0; id_wb_en = 0; id_dest = 0; id_mem_read = 0;
    wb_retire = 0; wb_dest = 0;
    model_reset();
    do_reset();

    // Load-use with bypass: LDR R2 then ADD R3 <- R2 stalls exactly once.
    s = nop(1); s.v = 1; s.wbe = 1; s.d = 4'd2; s.mr = 1; drive(s);
    s = nop(1); s.v = 1; s.s1 = 4'd2; s.wbe = 1; s.d = 4'd3; drive(s); drive(s);
    drive(nop(1));
    s = nop(1); s.ret = 1; s.wd = 4'd2; drive(s);
    s.wd = 4'd3; drive(s);

    // RAW without bypass: consumer of R4 waits until R4 retires.
    s = nop(0); s.v = 1; s.wbe = 1; s.d = 4'd4; drive(s);
    s = nop(0); s.v = 1; s.s1 = 4'd4; s.two = 1; s.s2 = 4'd15; s.wbe = 1; s.d = 4'd6;
    drive(s); drive(s);
    s.ret = 1; s.wd = 4'd4; drive(s);
    s = nop(0); s.ret = 1; s.wd = 4'd6; drive(s);

    // Retire and new producer of R5 in the same cycle; R15 sources never stall.
    s = nop(0); s.v = 1; s.wbe = 1; s.d = 4'd5; drive(s);
    s = nop(0); s.v = 1; s.s1 = 4'd15; s.two = 1; s.s2 = 4'd15; s.wbe = 1; s.d = 4'd5;
    s.ret = 1; s.wd = 4'd5; drive(s);
    s = nop(0); s.ret = 1; s.wd = 4'd5; drive(s);
    drive(nop(0));

    // Freeze for 4 cycles with R7 pending and a load in EXE.
    s = nop(1); s.v = 1; s.wbe = 1; s.d = 4'd7; s.mr = 1; drive(s);
    repeat (4) begin
      s = nop(1); s.fz = 1; s.ret = 1; s.wd = 4'd7; s.v = 1; s.s1 = 4'd7; s.wbe = 1; s.d = 4'd8;
      drive(s);
    end
    s = nop(1); s.v = 1; s.s1 = 4'd7; s.ret = 1; s.wd = 4'd7; drive(s);
    drive(nop(1)); drive(nop(1));

    // Overflow: four producers of R1 with nothing retiring.
    do_reset();
    repeat (4) begin
      s = nop(1); s.v = 1; s.wbe = 1; s.d = 4'd1; drive(s);
    end
    drive(nop(1));

    // Underflow: retire R9 with nothing outstanding.
    do_reset();
    s = nop(0); s.ret = 1; s.wd = 4'd9; drive(s);
    drive(nop(0)); drive(nop(0));

    // Random traffic with resets in between.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) drive(rand_stim());
      if (ph[0]) do_reset(); else async_reset();
    end
    drive(nop(0));
    drive(nop(0));
    @(negedge clk);
    #4;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain left=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
